// File: rtl/chien_search_if.sv
// Handshake and result bundle between the key-equation solver, the Chien search and the correction stage.
// The solver side drives start/locator; the search block returns the root positions and the failure flag.
interface chien_search_if #(
  parameter int MAX_ERRORS = 4
);
  localparam int CW = $clog2(MAX_ERRORS + 1);

  logic                      start;
  logic [53:0]               locator;
  logic                      finishFlag;
  logic [CW-1:0]             errCount;
  logic [6*MAX_ERRORS-1:0]   errPos;
  logic [MAX_ERRORS-1:0]     errValid;
  logic                      decFail;

  modport master (
    output start, locator,
    input  finishFlag, errCount, errPos, errValid, decFail
  );

  modport slave (
    input  start, locator,
    output finishFlag, errCount, errPos, errValid, decFail
  );
endinterface

// File: rtl/chien_search.sv
// Chien search over GF(2^6) (x^6+x+1): evaluates Lambda(x) at alpha^k for k=0..62, one point per clock,
// collects the error positions and flags the word uncorrectable when the root count disagrees with deg Lambda.
module chien_search #(
  parameter int N_SYMBOLS  = 63,
  parameter int MAX_ERRORS = 4
) (
  input  logic          clk,
  input  logic          resetN,
  chien_search_if.slave bus
);
  localparam int CW = $clog2(MAX_ERRORS + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SEARCH = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  function automatic logic [5:0] mul_alpha(input logic [5:0] a);
    return {a[4:0], 1'b0} ^ (a[5] ? 6'h03 : 6'h00);
  endfunction

  // Multiplication by the constant alpha^n collapses to a fixed XOR network after unrolling.
  function automatic logic [5:0] mul_alpha_pow(input logic [5:0] a, input int n);
    logic [5:0] r;
    r = a;
    for (int i = 0; i < n; i++) r = mul_alpha(r);
    return r;
  endfunction

  logic [2:0]                state_q, state_d;
  logic                      start_d_q;
  logic [5:0]                term_q [MAX_ERRORS+1];
  logic [5:0]                term_d [MAX_ERRORS+1];
  logic [5:0]                k_q, k_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [CW-1:0]             deg_q, deg_d;
  logic                      hi_nz_q, hi_nz_d;
  logic                      all_zero_q, all_zero_d;
  logic                      over_q, over_d;
  logic                      fin_q, fin_d;
  logic [CW-1:0]             err_count_q, err_count_d;
  logic [6*MAX_ERRORS-1:0]   err_pos_q, err_pos_d;
  logic [MAX_ERRORS-1:0]     err_valid_q, err_valid_d;
  logic                      dec_fail_q, dec_fail_d;

  logic                      start_edge;
  logic [5:0]                sum;
  logic [5:0]                pos;

  assign start_edge = bus.start & ~start_d_q;
  assign pos        = (k_q == 6'd0) ? 6'd0 : 6'd63 - k_q;

  always_comb begin
    sum = 6'd0;
    for (int j = 0; j <= MAX_ERRORS; j++) sum = sum ^ term_q[j];
  end

  always_comb begin
    // NOTE: every next-state variable gets its hold value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    deg_d       = deg_q;
    hi_nz_d     = hi_nz_q;
    all_zero_d  = all_zero_q;
    over_d      = over_q;
    fin_d       = 1'b0;
    err_count_d = err_count_q;
    err_pos_d   = err_pos_q;
    err_valid_d = err_valid_q;
    dec_fail_d  = dec_fail_q;
    for (int j = 0; j <= MAX_ERRORS; j++) term_d[j] = term_q[j];

    case (state_q)
      ST_IDLE: if (start_edge) state_d = ST_LOAD;

      ST_LOAD: begin
        k_d         = 6'd0;
        cnt_d       = '0;
        deg_d       = '0;
        hi_nz_d     = 1'b0;
        over_d      = 1'b0;
        err_count_d = '0;
        err_pos_d   = '0;
        err_valid_d = '0;
        dec_fail_d  = 1'b0;
        for (int j = 0; j <= MAX_ERRORS; j++) begin
          term_d[j] = bus.locator[6*j +: 6];
          if (bus.locator[6*j +: 6] != 6'd0) deg_d = CW'(j);
        end
        for (int j = MAX_ERRORS + 1; j < 9; j++)
          if (bus.locator[6*j +: 6] != 6'd0) hi_nz_d = 1'b1;
        all_zero_d = (bus.locator == 54'd0);
        state_d    = ST_SEARCH;
      end

      ST_SEARCH: begin
        // Roots beyond the slot capacity are not counted; the degree check still catches them as a mismatch.
        if (sum == 6'd0 && 32'(cnt_q) < MAX_ERRORS) begin
          err_pos_d[6*int'(cnt_q) +: 6] = pos;
          err_valid_d[cnt_q]            = 1'b1;
          cnt_d                         = cnt_q + 1'b1;
          if (32'(pos) >= N_SYMBOLS) over_d = 1'b1;
        end
        for (int j = 0; j <= MAX_ERRORS; j++) term_d[j] = mul_alpha_pow(term_q[j], j);
        k_d = k_q + 6'd1;
        if (k_q == 6'd62) state_d = ST_CHECK;
      end

      ST_CHECK: begin
        err_count_d = cnt_q;
        dec_fail_d  = hi_nz_q | all_zero_q | (cnt_q != deg_q) | over_q;
        fin_d       = 1'b1;
        state_d     = ST_DONE;
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the term registers are a handful of flops, not a RAM, so they are cleared by reset like the rest.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_IDLE;
      start_d_q   <= 1'b0;
      k_q         <= 6'd0;
      cnt_q       <= '0;
      deg_q       <= '0;
      hi_nz_q     <= 1'b0;
      all_zero_q  <= 1'b0;
      over_q      <= 1'b0;
      fin_q       <= 1'b0;
      err_count_q <= '0;
      err_pos_q   <= '0;
      err_valid_q <= '0;
      dec_fail_q  <= 1'b0;
      for (int j = 0; j <= MAX_ERRORS; j++) term_q[j] <= 6'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
      state_q     <= state_d;
      start_d_q   <= bus.start;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      deg_q       <= deg_d;
      hi_nz_q     <= hi_nz_d;
      all_zero_q  <= all_zero_d;
      over_q      <= over_d;
      fin_q       <= fin_d;
      err_count_q <= err_count_d;
      err_pos_q   <= err_pos_d;
      err_valid_q <= err_valid_d;
      dec_fail_q  <= dec_fail_d;
      for (int j = 0; j <= MAX_ERRORS; j++) term_q[j] <= term_d[j];
    end
  end

  assign bus.finishFlag = fin_q;
  assign bus.errCount   = err_count_q;
  assign bus.errPos     = err_pos_q;
  assign bus.errValid   = err_valid_q;
  assign bus.decFail    = dec_fail_q;
endmodule
